// File: rtl/mult_arbiter.sv
// Purpose: round-robin arbiter sharing one shift-add multiplier between two requesters.
// Latency: Ack one edge after a grantable IDLE cycle; Done one cycle after Mul_Ready returns high.
// Backpressure: no grant while Mul_Ready is low or a job is in flight; pending Reqs wait without loss.
module mult_arbiter #(
  parameter int ISSUE_LIMIT = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0,
  input  logic [7:0]  A0,
  input  logic [7:0]  B0,
  input  logic        Req1,
  input  logic [7:0]  A1,
  input  logic [7:0]  B1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Done0,
  output logic        Done1,
  output logic        Err,
  output logic [16:0] Result,
  output logic        Busy,
  output logic        Mul_Start,
  output logic [7:0]  Mul_A,
  output logic [7:0]  Mul_B,
  input  logic [16:0] Mul_Producto,
  input  logic        Mul_Ready
);

  localparam int CW = (ISSUE_LIMIT < 2) ? 1 : $clog2(ISSUE_LIMIT + 1);
  // Last count value still spent in ISSUE; the edge that sees it with Mul_Ready high aborts.
  localparam logic [CW-1:0] LIM_M1 = CW'(ISSUE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_gnt;     // requester currently owning the multiplier (0 or 1)
  logic          r_last;    // requester served last; 1 after reset so Req0 wins the first tie
  logic [CW-1:0] r_cnt;     // cycles spent in ISSUE with Mul_Ready still high
  logic          r_ack0;
  logic          r_ack1;
  logic          r_done0;
  logic          r_done1;
  logic          r_err;
  logic          r_busy;
  logic          r_start;
  logic [7:0]    r_mul_a;
  logic [7:0]    r_mul_b;
  logic [16:0]   r_result;

  logic w_any;
  logic w_pick1;

  // Round-robin pick: requester 1 wins when alone, or on a tie when 0 was served last.
  always_comb begin
    w_any   = Req0 | Req1;
    w_pick1 = Req1 & (~Req0 | ~r_last);
  end

  // Control FSM with all outputs registered; pulse outputs default low every cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_result <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Mul_Ready && w_any) begin
            r_gnt   <= w_pick1;
            r_last  <= w_pick1;
            r_mul_a <= w_pick1 ? A1 : A0;
            r_mul_b <= w_pick1 ? B1 : B0;
            r_ack0  <= ~w_pick1;
            r_ack1  <= w_pick1;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!Mul_Ready) begin
            // Multiplier accepted the job; release start and wait for completion.
            r_start <= 1'b0;
            r_state <= WAIT;
          end else if (r_cnt == LIM_M1) begin
            // Multiplier never accepted: abort with Err, Result untouched.
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (Mul_Ready) begin
            r_result <= Mul_Producto;
            r_done0  <= ~r_gnt;
            r_done1  <= r_gnt;
            r_state  <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_start <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Ack0      = r_ack0;
  assign Ack1      = r_ack1;
  assign Done0     = r_done0;
  assign Done1     = r_done1;
  assign Err       = r_err;
  assign Result    = r_result;
  assign Busy      = r_busy;
  assign Mul_Start = r_start;
  assign Mul_A     = r_mul_a;
  assign Mul_B     = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural shared multiplier.
// The multiplier model accepts a start, drops Mul_Ready for three cycles, then returns the product.
// Multiplier modes: 0 normal, 1 never accepts (Ready stuck high), 2 never finishes, 3 Ready held low.
module tb_mult_arbiter;

  logic        Clock;
  logic        Reset;
  logic        Req0, Req1;
  logic [7:0]  A0, B0, A1, B1;
  logic        Ack0, Ack1, Done0, Done1, Err, Busy, Mul_Start;
  logic [16:0] Result;
  logic [7:0]  Mul_A, Mul_B;
  logic [16:0] Mul_Producto;
  logic        Mul_Ready;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  logic        m_busy;
  int          m_cnt;
  logic [16:0] m_prod;

  mult_arbiter #(.ISSUE_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .A0(A0), .B0(B0),
    .Req1(Req1), .A1(A1), .B1(B1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1),
    .Err(Err), .Result(Result), .Busy(Busy),
    .Mul_Start(Mul_Start), .Mul_A(Mul_A), .Mul_B(Mul_B),
    .Mul_Producto(Mul_Producto), .Mul_Ready(Mul_Ready)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural shared multiplier.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Mul_Ready    <= 1'b1;
      Mul_Producto <= '0;
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      m_prod       <= '0;
    end else if (mode == 1) begin
      Mul_Ready <= 1'b1;
      m_busy    <= 1'b0;
    end else if (mode == 3) begin
      Mul_Ready <= 1'b0;
    end else if (!m_busy) begin
      if (!Mul_Ready) begin
        Mul_Ready <= 1'b1;
      end else if (Mul_Start) begin
        Mul_Ready <= 1'b0;
        m_busy    <= 1'b1;
        m_cnt     <= 2;
        m_prod    <= 17'(Mul_A) * 17'(Mul_B);
      end
    end else if (mode == 0) begin
      if (m_cnt == 0) begin
        Mul_Ready    <= 1'b1;
        Mul_Producto <= m_prod;
        m_busy       <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Req0 = 0; Req1 = 0; A0 = 0; B0 = 0; A1 = 0; B1 = 0;
    #2;
    n_cmp++;
    if ({Ack0, Ack1, Done0, Done1, Err, Busy, Mul_Start} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000000", {Ack0, Ack1, Done0, Done1, Err, Busy, Mul_Start});
    end
    n_cmp++;
    if (Result !== 17'd0 || Mul_A !== 8'd0 || Mul_B !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_data: got Result=%0d Mul_A=%0d Mul_B=%0d want 0 0 0", Result, Mul_A, Mul_B);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    n_cmp++;
    if (Busy !== 1'b0 || Ack0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got Busy=%b Ack0=%b want 0 0", Busy, Ack0);
    end
  endtask

  // Tie right after reset goes to 0; a tie formed while busy then goes to 1; A0 change after Ack is ignored.
  task automatic test_tie();
    int k;
    int exp_who [3];
    int exp_res [3];
    exp_who[0] = 0; exp_who[1] = 1; exp_who[2] = 0;
    exp_res[0] = 65025; exp_res[1] = 0; exp_res[2] = 12;
    Req0 = 1; A0 = 255; B0 = 255;
    Req1 = 1; A1 = 0;   B1 = 7;
    for (int j = 0; j < 3; j++) begin
      k = 0;
      while (!(Ack0 || Ack1) && k < 20) begin tick(); k++; end
      n_cmp++;
      if (k >= 20 || Ack0 !== (exp_who[j] == 0) || Ack1 !== (exp_who[j] == 1)) begin
        n_bad++;
        $display("FAIL tie_ack job%0d: got Ack0=%b Ack1=%b want requester %0d", j, Ack0, Ack1, exp_who[j]);
      end
      if (j == 0) begin A0 = 3; B0 = 4; end
      if (j == 1) Req1 = 0;
      if (j == 2) Req0 = 0;
      k = 0;
      while (!(Done0 || Done1) && k < 20) begin tick(); k++; end
      n_cmp++;
      if (k >= 20 || Done0 !== (exp_who[j] == 0) || Done1 !== (exp_who[j] == 1) || Err !== 1'b0) begin
        n_bad++;
        $display("FAIL tie_done job%0d: got Done0=%b Done1=%b Err=%b want requester %0d no Err",
                 j, Done0, Done1, Err, exp_who[j]);
      end
      n_cmp++;
      if (Result !== 17'(exp_res[j])) begin
        n_bad++;
        $display("FAIL tie_result job%0d: got %0d want %0d", j, Result, exp_res[j]);
      end
    end
    tick();
  endtask

  // No grant while the multiplier reports not-ready in IDLE.
  task automatic test_no_ready_idle();
    int k;
    logic seen;
    mode = 3;
    tick();
    tick();
    Req0 = 1; A0 = 1; B0 = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Ack0 !== 1'b0 || Busy !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL no_ready_grant: got a grant while Mul_Ready low, want none");
    end
    mode = 0;
    k = 0;
    while (!Ack0 && k < 10) begin tick(); k++; end
    n_cmp++;
    if (Ack0 !== 1'b1) begin
      n_bad++;
      $display("FAIL no_ready_resume: got Ack0=%b want 1", Ack0);
    end
    Req0 = 0;
    k = 0;
    while (!Done0 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (Done0 !== 1'b1 || Result !== 17'd1) begin
      n_bad++;
      $display("FAIL no_ready_result: got Done0=%b Result=%0d want 1 1", Done0, Result);
    end
    tick();
  endtask

  // Single job 13*11 with exact handshake timing.
  task automatic test_single();
    int k;
    logic bad_done;
    Req0 = 1; A0 = 13; B0 = 11; Req1 = 0;
    k = 0;
    while (!Ack0 && k < 10) begin tick(); k++; end
    n_cmp++;
    if (Ack0 !== 1'b1 || Ack1 !== 1'b0 || Mul_Start !== 1'b1 || Mul_A !== 8'd13 || Mul_B !== 8'd11) begin
      n_bad++;
      $display("FAIL single_grant: got Ack0=%b Ack1=%b Start=%b A=%0d B=%0d want 1 0 1 13 11",
               Ack0, Ack1, Mul_Start, Mul_A, Mul_B);
    end
    Req0 = 0; A0 = 99; B0 = 1;
    k = 0;
    while (Mul_Ready === 1'b1 && k < 10) begin tick(); k++; end
    n_cmp++;
    if (Mul_Start !== 1'b1 || Ack0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_start_held: got Start=%b Ack0=%b want 1 0", Mul_Start, Ack0);
    end
    tick();
    n_cmp++;
    if (Mul_Start !== 1'b0 || Busy !== 1'b1 || Mul_A !== 8'd13 || Mul_B !== 8'd11) begin
      n_bad++;
      $display("FAIL single_wait: got Start=%b Busy=%b A=%0d B=%0d want 0 1 13 11", Mul_Start, Busy, Mul_A, Mul_B);
    end
    bad_done = 0;
    k = 0;
    while (Mul_Ready !== 1'b1 && k < 10) begin
      if (Done0 !== 1'b0) bad_done = 1;
      tick();
      k++;
    end
    if (Done0 !== 1'b0) bad_done = 1;
    tick();
    n_cmp++;
    if (bad_done || Done0 !== 1'b1 || Done1 !== 1'b0 || Err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done_timing: got Done0=%b Done1=%b Err=%b early=%b want 1 0 0 0",
               Done0, Done1, Err, bad_done);
    end
    n_cmp++;
    if (Result !== 17'd143) begin
      n_bad++;
      $display("FAIL single_result: got %0d want 143", Result);
    end
    tick();
    n_cmp++;
    if (Done0 !== 1'b0 || Busy !== 1'b0 || Result !== 17'd143) begin
      n_bad++;
      $display("FAIL single_after: got Done0=%b Busy=%b Result=%0d want 0 0 143", Done0, Busy, Result);
    end
  endtask

  // Multiplier never accepts: abort after four Mul_Start cycles, Result retained.
  task automatic test_timeout();
    int k;
    int n_start;
    mode = 1;
    tick();
    Req0 = 1; A0 = 5; B0 = 5;
    k = 0;
    while (!Ack0 && k < 10) begin tick(); k++; end
    Req0 = 0;
    n_start = 0;
    k = 0;
    while (!Done0 && k < 20) begin
      if (Mul_Start) n_start++;
      tick();
      k++;
    end
    n_cmp++;
    if (n_start != 4) begin
      n_bad++;
      $display("FAIL timeout_start_cycles: got %0d want 4", n_start);
    end
    n_cmp++;
    if (Done0 !== 1'b1 || Err !== 1'b1 || Done1 !== 1'b0 || Mul_Start !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got Done0=%b Err=%b Done1=%b Start=%b want 1 1 0 0", Done0, Err, Done1, Mul_Start);
    end
    n_cmp++;
    if (Result !== 17'd143) begin
      n_bad++;
      $display("FAIL timeout_result: got %0d want 143", Result);
    end
    tick();
    n_cmp++;
    if (Busy !== 1'b0 || Err !== 1'b0 || Done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: got Busy=%b Err=%b Done0=%b want 0 0 0", Busy, Err, Done0);
    end
    mode = 0;
    tick();
  endtask

  // Req1 held across its Done: one IDLE cycle, then regrant with the new A1.
  task automatic test_back_to_back();
    int k;
    Req1 = 1; A1 = 2; B1 = 3;
    k = 0;
    while (!Ack1 && k < 10) begin tick(); k++; end
    A1 = 4;
    k = 0;
    while (!Done1 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (Done1 !== 1'b1 || Result !== 17'd6) begin
      n_bad++;
      $display("FAIL b2b_first: got Done1=%b Result=%0d want 1 6", Done1, Result);
    end
    tick();
    n_cmp++;
    if (Busy !== 1'b0 || Ack1 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got Busy=%b Ack1=%b want 0 0", Busy, Ack1);
    end
    tick();
    n_cmp++;
    if (Ack1 !== 1'b1 || Ack0 !== 1'b0 || Mul_A !== 8'd4 || Mul_B !== 8'd3) begin
      n_bad++;
      $display("FAIL b2b_regrant: got Ack1=%b Ack0=%b A=%0d B=%0d want 1 0 4 3", Ack1, Ack0, Mul_A, Mul_B);
    end
    Req1 = 0;
    k = 0;
    while (!Done1 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (Done1 !== 1'b1 || Result !== 17'd12) begin
      n_bad++;
      $display("FAIL b2b_second: got Done1=%b Result=%0d want 1 12", Done1, Result);
    end
    tick();
  endtask

  // Asynchronous reset while waiting on the multiplier discards the job.
  task automatic test_reset_wait();
    int k;
    logic seen;
    mode = 2;
    Req0 = 1; A0 = 7; B0 = 7;
    k = 0;
    while (!Ack0 && k < 10) begin tick(); k++; end
    Req0 = 0;
    k = 0;
    while (!(Busy && !Mul_Start && !Mul_Ready) && k < 10) begin tick(); k++; end
    n_cmp++;
    if (Busy !== 1'b1 || Mul_Start !== 1'b0) begin
      n_bad++;
      $display("FAIL rstwait_reach: got Busy=%b Start=%b want 1 0", Busy, Mul_Start);
    end
    #2;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({Ack0, Ack1, Done0, Done1, Err, Busy, Mul_Start} !== 7'd0 ||
        Result !== 17'd0 || Mul_A !== 8'd0 || Mul_B !== 8'd0) begin
      n_bad++;
      $display("FAIL rstwait_async: got ctrl=%b Result=%0d A=%0d B=%0d want all 0",
               {Ack0, Ack1, Done0, Done1, Err, Busy, Mul_Start}, Result, Mul_A, Mul_B);
    end
    tick();
    tick();
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done0 !== 1'b0 || Done1 !== 1'b0 || Busy !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0 || Mul_Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstwait_no_done: got spurious activity=%b Mul_Ready=%b want 0 1", seen, Mul_Ready);
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_no_ready_idle();
    test_single();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
